lut_neuron_loader: RTL
======================

# lut_neuron_loader

Runtime-programmable LogicNet neuron: the write side of the fixed truth-table neurons the synthesis flow emits as distributed ROM. It accepts the truth table as a packed, valid/ready configuration stream, stores it in distributed RAM and then serves registered lookups. It is used in place of a hard-coded layer neuron whenever a table must be reloaded in the field, and for on-board checks of generated tables.

## Interface
- IN_BITS, 8, neuron fan-in bits; table depth is 2^IN_BITS entries.
- OUT_BITS, 1, bits per table entry.
- CFG_W, 8, configuration beat width. CFG_W must be a multiple of OUT_BITS, and 2^IN_BITS*OUT_BITS must be a multiple of CFG_W.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  configuration beat valid.
- cfg_ready  out  1  configuration beat accepted when cfg_valid & cfg_ready.
- cfg_data  in  CFG_W  packed table entries.
- cfg_last  in  1  marks the final beat of a table.
- cfg_err  out  1  one-cycle pulse on a framing error.
- loaded  out  1  high while a complete table is held.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  neuron input code (same signal as M0 of a generated neuron).
- out_valid  out  1  lookup result valid.
- out_data  out  OUT_BITS  neuron output.

## Operation
- Entry ordering matches the generated tables. Entry index i corresponds to the in_data code whose bit [IN_BITS-1-j] equals bit j of i. Example: entry 1 is 8'h80 and entry 128 is 8'h01.
- Beat packing: E = CFG_W/OUT_BITS entries per beat. Beat b bits [k*OUT_BITS +: OUT_BITS] hold entry b*E+k.
- NB = 2^IN_BITS*OUT_BITS/CFG_W beats per table. The default is 32.
- FSM states:
  - EMPTY: cfg_ready=1, loaded=0. An accepted beat writes beat 0 and moves to LOADING with beat counter=1. If NB=1 and cfg_last=1, it moves directly to READY.
  - LOADING: cfg_ready=1. Each accepted beat writes at the counter and increments it.
    - If cfg_last arrives on beat NB-1: go to READY.
    - If cfg_last arrives on any earlier beat, or beat NB-1 arrives without cfg_last: pulse cfg_err and go to EMPTY. The partially written RAM is not cleared.
  - READY: loaded=1, cfg_ready=1. An accepted beat starts a reload: loaded drops to 0 the next cycle, beat 0 is written, and the state moves to LOADING.
- Lookups are honoured only in READY. While not READY, in_valid is ignored and out_valid stays 0.
- In the cycle a reload beat is accepted in READY, a same-cycle in_valid is still served from the old contents of the addressed entry.
- The beat counter is $clog2(NB) bits. It never wraps, because beat NB-1 always exits LOADING.

## Timing
- Reset values: state EMPTY, cfg_ready=1, cfg_err=0, loaded=0, out_valid=0, out_data=0. RAM contents are not reset.
- Reset mid-load returns to EMPTY, discards the beat count and raises no cfg_err.
- Lookup latency is 1 cycle: out_valid(t+1)=in_valid(t)&READY(t), and out_data is registered. Full throughput, one lookup per cycle.
- out_data holds its value when out_valid=0.
- cfg_err is asserted in the cycle after the offending beat.
- The loaded transition to 1 occurs in the cycle after the last beat, which is also the first cycle in which a lookup is honoured.
- No backpressure on the lookup path.

## Configuration
- Macro LUT_NEURON_READBACK_EN.
- When defined, three extra ports are added:
  - rd_en in 1.
  - rd_beat in $clog2(NB).
  - rd_data out CFG_W.
- Readback behaviour: rd_data is registered, 1-cycle latency, and returns beat rd_beat in the same packing as the write stream. It is valid in any state, and its reset value is 0.
- When the macro is undefined, these ports and the read mux are absent.

## Test plan
- Reset, then in_valid=1 with in_data=8'h00 -> out_valid stays 0; after reset cfg_ready=1 and loaded=0.
- Load 32 beats, all 8'hFF except beat 0 = 8'hFD, with cfg_last on beat 31 -> loaded=1 one cycle after beat 31. Then in_data 8'h80 -> out_data 0; in_data 8'h01 -> 1; 8'h00 -> 1; each result 1 cycle after its request.
- Set cfg_last on beat 5 -> cfg_err pulses once, loaded=0, lookups are ignored; a following full valid load succeeds.
- Send 32 beats without cfg_last -> cfg_err after beat 31 and state EMPTY.
- From READY, start a reload with beat 0 = 8'h00 while issuing back-to-back lookups of 8'h00 -> the same-cycle lookup returns 1 (old contents); the next lookup is dropped (out_valid=0).
- Assert rst during beat 10 of a load -> EMPTY, no cfg_err. With LUT_NEURON_READBACK_EN defined, after a full load rd_beat=0 returns 8'hFD one cycle after rd_en.

Source files
------------

// File: rtl/lut_neuron_loader_if.sv
// Configuration stream and lookup port bundle for lut_neuron_loader.
// The master side drives configuration beats and lookups; the slave side is the neuron.
interface lut_neuron_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                cfg_err;
    logic                loaded;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        input  cfg_ready, cfg_err, loaded, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        output cfg_ready, cfg_err, loaded, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LogicNet truth-table neuron held in distributed RAM with registered lookups.
// Define LUT_NEURON_READBACK_EN to add the rd_en/rd_beat/rd_data table readback port.
module lut_neuron_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8,
    localparam int E  = CFG_W / OUT_BITS,
    localparam int NB = ((2 ** IN_BITS) * OUT_BITS) / CFG_W,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_neuron_loader_if.slave   bus
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic                 rd_en,
    input  logic [BW-1:0]        rd_beat,
    output logic [CFG_W-1:0]     rd_data
`endif
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_LOADING = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;

    logic [1:0]          state;
    logic [BW-1:0]       beat_cnt;
    logic [BW-1:0]       beat_idx;
    logic                accept;
    logic                is_final;
    logic                lookup_ok;
    logic [CFG_W-1:0]    mem [NB];
    logic [IN_BITS-1:0]  entry_idx;
    logic [BW-1:0]       lookup_beat;
    logic [CFG_W-1:0]    lookup_word;
    logic [OUT_BITS-1:0] lookup_bits;
    int                  entry_off;

    assign bus.cfg_ready = 1'b1;
    assign bus.loaded    = (state == S_READY);
    assign accept        = bus.cfg_valid & bus.cfg_ready;
    assign lookup_ok     = bus.in_valid & (state == S_READY);

    // Every first beat (from EMPTY or a reload from READY) lands in slot 0.
    assign beat_idx = (state == S_LOADING) ? beat_cnt : '0;
    assign is_final = (beat_idx == BW'(NB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_EMPTY;
            beat_cnt     <= '0;
            bus.cfg_err  <= 1'b0;
        end else begin
            bus.cfg_err <= 1'b0;
            if (accept) begin
                if (bus.cfg_last && is_final) begin
                    state <= S_READY;
                end else if (bus.cfg_last || is_final) begin
                    state       <= S_EMPTY;
                    bus.cfg_err <= 1'b1;
                end else begin
                    state    <= S_LOADING;
                    beat_cnt <= beat_idx + 1'b1;
                end
            end
        end
    end

    // Table storage keeps the write-stream packing, one beat per word; never reset.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[beat_idx] <= bus.cfg_data;
        end
    end

    // Generated tables index entries with the input code bit-reversed.
    always_comb begin
        entry_idx   = '0;
        lookup_bits = '0;
        for (int j = 0; j < IN_BITS; j++) begin
            entry_idx[j] = bus.in_data[IN_BITS-1-j];
        end
        lookup_beat = BW'(int'(entry_idx) / E);
        entry_off   = int'(entry_idx) % E;
        lookup_word = mem[lookup_beat];
        for (int k = 0; k < E; k++) begin
            if (entry_off == k) begin
                lookup_bits = lookup_word[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= lookup_ok;
            if (lookup_ok) begin
                bus.out_data <= lookup_bits;
            end
        end
    end

`ifdef LUT_NEURON_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_beat];
        end
    end
`endif

endmodule
